// File: rtl/rtc_bus_driver_if.sv
// Multiplexed address/data bus between the driver and the RTC chip.
// The top level owns the tristate and merges ad_out/ad_oe/ad_in onto one pad set.
interface rtc_bus_driver_if;
   logic       cs_n;
   logic       rd_n;
   logic       wr_n;
   logic       ad_sel;
   logic       ad_oe;
   logic [7:0] ad_out;
   logic [7:0] ad_in;

   modport master (
      output cs_n,
      output rd_n,
      output wr_n,
      output ad_sel,
      output ad_oe,
      output ad_out,
      input  ad_in
   );

   modport slave (
      input  cs_n,
      input  rd_n,
      input  wr_n,
      input  ad_sel,
      input  ad_oe,
      input  ad_out,
      output ad_in
   );
endinterface

// File: rtl/rtc_bus_driver.sv
// Single-transaction RTC bus driver: an address phase followed by a write or read data phase,
// each split into setup/strobe/hold of T_PH cycles, then a completion pulse and a two-cycle guard gap.
module rtc_bus_driver #(
   parameter int T_PH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           dirout,
   input  logic [7:0]           dato,
   input  logic                 escritura,
   input  logic                 lectura,
   input  logic                 write,
   input  logic [3:0]           dir_reg,
   output logic                 fin,
   output logic                 busy,
   output logic [7:0]           dato_leido,
   output logic                 reg_we,
   output logic [3:0]           reg_addr,
   rtc_bus_driver_if.master     bus
);

   localparam logic [3:0] PH_LAST = 4'(T_PH - 1);

   typedef enum logic [3:0] {
      IDLE,
      ADDR_SETUP,
      ADDR_STROBE,
      ADDR_HOLD,
      DATA_SETUP,
      DATA_STROBE,
      DATA_HOLD,
      DONE,
      GAP
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [3:0] cnt;
   logic [3:0] cnt_next;
   logic       phase_done;
   logic       accept;

   logic [7:0] addr_q;
   logic [7:0] data_q;
   logic       is_write_q;
   logic       store_q;
   logic [3:0] dir_q;
   logic [7:0] last_out;

   logic       cs_n_c;
   logic       rd_n_c;
   logic       wr_n_c;
   logic       ad_sel_c;
   logic       ad_oe_c;
   logic [7:0] ad_out_c;
   logic       fin_c;
   logic       reg_we_c;

   assign phase_done = (cnt == PH_LAST);
   assign accept     = (state == IDLE) && (escritura || lectura);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Phase states share one counter that wraps at T_PH; GAP reuses it to count its two cycles.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            cnt_next = 4'd0;
            if (accept) state_next = ADDR_SETUP;
         end
         ADDR_SETUP, ADDR_STROBE, ADDR_HOLD,
         DATA_SETUP, DATA_STROBE, DATA_HOLD: begin
            cnt_next = phase_done ? 4'd0 : cnt + 4'd1;
            if (phase_done) begin
               case (state)
                  ADDR_SETUP:  state_next = ADDR_STROBE;
                  ADDR_STROBE: state_next = ADDR_HOLD;
                  ADDR_HOLD:   state_next = DATA_SETUP;
                  DATA_SETUP:  state_next = DATA_STROBE;
                  DATA_STROBE: state_next = DATA_HOLD;
                  default:     state_next = DONE;
               endcase
            end
         end
         DONE: begin
            cnt_next   = 4'd0;
            state_next = GAP;
         end
         GAP: begin
            if (cnt == 4'd1) begin
               cnt_next   = 4'd0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt + 4'd1;
            end
         end
         default: begin
            cnt_next   = 4'd0;
            state_next = IDLE;
         end
      endcase
   end

   // Bus outputs decode purely from state, so an asynchronous reset releases the bus at once.
   always_comb begin
      cs_n_c   = 1'b1;
      rd_n_c   = 1'b1;
      wr_n_c   = 1'b1;
      ad_sel_c = 1'b1;
      ad_oe_c  = 1'b0;
      ad_out_c = last_out;
      fin_c    = 1'b0;
      reg_we_c = 1'b0;
      case (state)
         ADDR_SETUP, ADDR_STROBE, ADDR_HOLD: begin
            cs_n_c   = 1'b0;
            ad_sel_c = 1'b0;
            ad_oe_c  = 1'b1;
            ad_out_c = addr_q;
            wr_n_c   = (state != ADDR_STROBE);
         end
         DATA_SETUP, DATA_STROBE, DATA_HOLD: begin
            cs_n_c   = 1'b0;
            ad_sel_c = 1'b1;
            if (is_write_q) begin
               ad_oe_c  = 1'b1;
               ad_out_c = data_q;
               wr_n_c   = (state != DATA_STROBE);
            end else begin
               rd_n_c   = (state != DATA_STROBE);
            end
         end
         DONE: begin
            fin_c    = 1'b1;
            reg_we_c = !is_write_q && store_q;
         end
         default: begin
            cs_n_c = 1'b1;
         end
      endcase
   end

   // Request fields are frozen at acceptance; read data is taken on the final strobe edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q     <= 8'd0;
         data_q     <= 8'd0;
         is_write_q <= 1'b0;
         store_q    <= 1'b0;
         dir_q      <= 4'd0;
         dato_leido <= 8'd0;
         last_out   <= 8'd0;
      end else begin
         last_out <= ad_out_c;
         if (accept) begin
            addr_q     <= dirout;
            data_q     <= dato;
            is_write_q <= escritura;
            store_q    <= write;
            dir_q      <= dir_reg;
         end
         if ((state == DATA_STROBE) && phase_done && !is_write_q) begin
            dato_leido <= bus.ad_in;
         end
      end
   end

   assign bus.cs_n   = cs_n_c;
   assign bus.rd_n   = rd_n_c;
   assign bus.wr_n   = wr_n_c;
   assign bus.ad_sel = ad_sel_c;
   assign bus.ad_oe  = ad_oe_c;
   assign bus.ad_out = ad_out_c;
   assign fin        = fin_c;
   assign reg_we     = reg_we_c;
   assign busy       = (state != IDLE);
   assign reg_addr   = dir_q;

endmodule
